// File: rtl/dense_int_collect_if.sv
// Bus interface for dense_int_collect: serial int8 byte input, wide vector
// output with valid/ready handshake, sticky overflow and fill-count debug.
// Optional argmax/max outputs exist only when COLLECT_ARGMAX_EN is defined.
//   slave  : collector side (consumes bytes, produces vectors)
//   master : producer/consumer side (drives bytes and ready_i)
interface dense_int_collect_if #(
  parameter int unsigned B          = 64,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned IDX_W = $clog2(B);

  logic                         valid_i;
  logic [DATA_WIDTH-1:0]        data_i;
  logic [B*DATA_WIDTH-1:0]      data_o;
  logic                         valid_o;
  logic                         ready_i;
  logic                         overflow_o;
  logic [IDX_W-1:0]             cnt_o;
`ifdef COLLECT_ARGMAX_EN
  logic [IDX_W-1:0]             argmax_o;
  logic signed [DATA_WIDTH-1:0] max_o;
`endif

  modport slave (
    input  valid_i, data_i, ready_i,
`ifdef COLLECT_ARGMAX_EN
    output argmax_o, max_o,
`endif
    output data_o, valid_o, overflow_o, cnt_o
  );

  modport master (
    output valid_i, data_i, ready_i,
`ifdef COLLECT_ARGMAX_EN
    input  argmax_o, max_o,
`endif
    input  data_o, valid_o, overflow_o, cnt_o
  );
endinterface

// File: rtl/dense_int_collect.sv
// dense_int_collect: gathers B serial signed bytes into one wide vector and
// presents it with valid/ready. A fill buffer plus output register let one
// vector be held while the next streams in; bytes arriving while both are
// full are dropped and flagged on the sticky overflow_o.
// Ports: clk, rstn (async active-low), bus (dense_int_collect_if.slave):
//   valid_i/data_i byte input, data_o/valid_o/ready_i vector output,
//   overflow_o sticky drop flag, cnt_o bytes currently in the fill buffer.
// Optional: define COLLECT_ARGMAX_EN to add argmax_o/max_o (running signed
// maximum of each vector, ties keep the lowest index).
module dense_int_collect #(
  parameter int unsigned B          = 64,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  dense_int_collect_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(B);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(B - 1);

  logic [B-1:0][DATA_WIDTH-1:0] fill_q, fill_d;
  logic [B-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]             cnt_q, cnt_d;
  logic                         valid_q, valid_d;
  logic                         pend_q, pend_d;
  logic                         ovf_q, ovf_d;
  logic                         accept_c, last_c, consume_c;
`ifdef COLLECT_ARGMAX_EN
  logic signed [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic [IDX_W-1:0]             run_arg_q, run_arg_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic [IDX_W-1:0]             arg_q, arg_d;
`endif

  // Next-state: fill, completion, output handshake, overflow
  always_comb begin
    fill_d    = fill_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
`ifdef COLLECT_ARGMAX_EN
    run_max_d = run_max_q;
    run_arg_d = run_arg_q;
    max_d     = max_q;
    arg_d     = arg_q;
`endif

    // pending is sampled pre-edge, so a byte arriving as ready_i frees it is still lost
    accept_c  = bus.valid_i & ~pend_q;
    last_c    = accept_c & (cnt_q == LAST_IDX);
    consume_c = valid_q & bus.ready_i;

    if (accept_c) begin
      fill_d[cnt_q] = bus.data_i;
      cnt_d         = last_c ? '0 : cnt_q + IDX_W'(1);
`ifdef COLLECT_ARGMAX_EN
      // first byte seeds the tracker; strict compare keeps the lowest index on ties
      if ((cnt_q == '0) || ($signed(bus.data_i) > run_max_q)) begin
        run_max_d = $signed(bus.data_i);
        run_arg_d = cnt_q;
      end
`endif
    end

    if (bus.valid_i & pend_q) begin
      ovf_d = 1'b1;
    end

    if (last_c && (!valid_q || bus.ready_i)) begin
      // output register free (or being freed): load the just-completed vector
      data_d  = fill_d;
      valid_d = 1'b1;
`ifdef COLLECT_ARGMAX_EN
      max_d   = run_max_d;
      arg_d   = run_arg_d;
`endif
    end else if (last_c) begin
      pend_d = 1'b1;
    end else if (consume_c) begin
      if (pend_q) begin
        // back-to-back: the held vector moves straight into the output register
        data_d = fill_q;
        pend_d = 1'b0;
`ifdef COLLECT_ARGMAX_EN
        max_d  = run_max_q;
        arg_d  = run_arg_q;
`endif
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef COLLECT_ARGMAX_EN
      run_max_q <= '0;
      run_arg_q <= '0;
      max_q     <= '0;
      arg_q     <= '0;
`endif
    end else begin
      fill_q    <= fill_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
`ifdef COLLECT_ARGMAX_EN
      run_max_q <= run_max_d;
      run_arg_q <= run_arg_d;
      max_q     <= max_d;
      arg_q     <= arg_d;
`endif
    end
  end

  assign bus.data_o     = data_q;
  assign bus.valid_o    = valid_q;
  assign bus.overflow_o = ovf_q;
  assign bus.cnt_o      = cnt_q;
`ifdef COLLECT_ARGMAX_EN
  assign bus.argmax_o   = arg_q;
  assign bus.max_o      = max_q;
`endif

endmodule

// File: tb/tb_dense_int_collect.sv
// Bench for dense_int_collect (B=4): directed scenarios plus random traffic,
// checked against an occupancy/queue reference model via a scoreboard.
module tb_dense_int_collect;
  localparam int unsigned B  = 4;
  localparam int unsigned DW = 8;

  typedef struct {
    logic [B*DW-1:0] vec;
    int              arg;
    logic [DW-1:0]   mx;
  } exp_t;

  typedef struct {
    logic vld;
    int   cnt;
    logic ovf;
  } st_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dense_int_collect_if #(.B(B), .DATA_WIDTH(DW)) bus ();
  dense_int_collect #(.B(B), .DATA_WIDTH(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  exp_t        exp_q[$];
  st_t         st_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // reference model: number of vectors held (output reg + pending), partial bytes
  int          held;
  logic [7:0]  part[$];
  logic        ovf_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    e.vec = '0;
    e.mx  = part[0];
    e.arg = 0;
    for (int k = 0; k < B; k++) begin
      e.vec[k*DW +: DW] = part[k];
      if ($signed(part[k]) > $signed(e.mx)) begin
        e.mx  = part[k];
        e.arg = k;
      end
    end
    return e;
  endfunction

  // one clock of stimulus plus the model's view of the coming edge
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    st_t s;
    logic comp;
    logic cons;
    @(negedge clk);
    bus.valid_i = v;
    bus.data_i  = d;
    bus.ready_i = r;
    comp = 1'b0;
    if (v && held == 2) begin
      ovf_m = 1'b1;
    end else if (v) begin
      part.push_back(d);
      if (part.size() == B) begin
        exp_q.push_back(make_exp());
        part.delete();
        comp = 1'b1;
      end
    end
    cons = r && (held > 0);
    held = held + int'(comp) - int'(cons);
    s.vld = (held > 0);
    s.cnt = part.size();
    s.ovf = ovf_m;
    st_q.push_back(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn        = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    #1;
    check("rst_data", 64'(bus.data_o), 64'h0);
    check("rst_valid", 64'(bus.valid_o), 64'h0);
    check("rst_cnt", 64'(bus.cnt_o), 64'h0);
    check("rst_ovf", 64'(bus.overflow_o), 64'h0);
`ifdef COLLECT_ARGMAX_EN
    check("rst_argmax", 64'(bus.argmax_o), 64'h0);
    check("rst_max", 64'(bus.max_o), 64'h0);
`endif
    exp_q.delete();
    st_q.delete();
    part.delete();
    held  = 0;
    ovf_m = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic send_vec(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input logic r);
    cycle(1'b1, b0, r);
    cycle(1'b1, b1, r);
    cycle(1'b1, b2, r);
    cycle(1'b1, b3, r);
  endtask

  // status monitor: registered state just after each edge
  initial begin
    st_t s;
    forever begin
      @(posedge clk);
      #1;
      if (rstn && st_q.size() > 0) begin
        s = st_q.pop_front();
        check("valid_o", 64'(bus.valid_o), 64'(s.vld));
        check("cnt_o", 64'(bus.cnt_o), 64'(s.cnt));
        check("overflow_o", 64'(bus.overflow_o), 64'(s.ovf));
      end
    end
  end

  // vector monitor: every handshake pops the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rstn && bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_vector", 64'(bus.data_o), 64'hDEAD_BEEF_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("data_o", 64'(bus.data_o), 64'(e.vec));
`ifdef COLLECT_ARGMAX_EN
          check("argmax_o", 64'(bus.argmax_o), 64'(e.arg));
          check("max_o", 64'(bus.max_o), 64'(e.mx));
`endif
        end
      end
    end
  end

  initial begin
    rstn        = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b0;
    held        = 0;
    ovf_m       = 1'b0;
    do_reset();

    // single vector with downstream always ready
    send_vec(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // two vectors held, then a dropped byte, then drain both
    send_vec(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    send_vec(8'h05, 8'h06, 8'h07, 8'h08, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h7F, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // reset mid-vector with a vector held in the output register
    send_vec(8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b0);
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    do_reset();
    send_vec(8'h09, 8'h0A, 8'h0B, 8'h0C, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // last byte coincides with ready_i: no bubble
    send_vec(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    cycle(1'b1, 8'h05, 1'b0);
    cycle(1'b1, 8'h06, 1'b0);
    cycle(1'b1, 8'h07, 1'b0);
    cycle(1'b1, 8'h08, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // signed maximum and tie handling
    send_vec(8'h80, 8'h05, 8'h7F, 8'h7F, 1'b1);
    send_vec(8'hF0, 8'hF0, 8'hF0, 8'hF0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // random traffic with varying downstream pressure
    for (int blk = 0; blk < 6; blk++) begin
      int unsigned rp;
      rp = $urandom_range(1, 9);
      for (int i = 0; i < 400; i++) begin
        cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 9) < rp));
      end
      if (blk == 2) do_reset();
    end

    // drain
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("leftover_vectors", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
